// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_ADDIEX  = 4'd8,
    S_SLTIEX  = 4'd9,
    S_IMMWB   = 4'd10,
    S_BRANCH  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       pc_src;
  } ctrl_t;

  // Every strobe low, ALU defaulting to ADD.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = '0;
    c.alu_control = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Funct field to ALUControl decode; unknown Funct falls back to ADD and is flagged.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       illegal_funct_o
);

  always_comb begin
    alu_control_o   = ALU_ADD;
    illegal_funct_o = 1'b0;
    case (funct_i)
      FN_ADD:  alu_control_o = ALU_ADD;
      FN_SUB:  alu_control_o = ALU_SUB;
      FN_AND:  alu_control_o = ALU_AND;
      FN_OR:   alu_control_o = ALU_OR;
      FN_SLT:  alu_control_o = ALU_SLT;
      FN_NOR:  alu_control_o = ALU_NOR;
      default: illegal_funct_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences the datapath, counts retired
// instructions and keeps a sticky illegal-instruction flag.
//   state    | meaning
//   FETCH    | read instr, PC <= PC+4
//   DECODE   | branch target into ALUOut, dispatch on OP
//   MEMADR   | base + offset
//   MEMRD    | data memory read
//   MEMWB    | load writeback to rt
//   MEMWR    | data memory write
//   EXECUTE  | R-type ALU op
//   ALUWB    | R-type writeback to rd
//   ADDIEX   | addi ALU op
//   SLTIEX   | slti ALU op
//   IMMWB    | immediate writeback to rt
//   BRANCH   | beq compare, PC <= ALUOut if Zero
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OP,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  output logic                 PCWrite,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [3:0]           ALUControl,
  output logic                 PCSrc,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] instr_count_o,
  output logic [3:0]           state_o
);

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  ctrl_t      ctrl;
  logic       set_illegal;
  logic       retire;
  logic [3:0] funct_alu_ctrl;
  logic       illegal_funct;

  alu_decoder u_alu_decoder (
    .funct_i         (Funct),
    .alu_control_o   (funct_alu_ctrl),
    .illegal_funct_o (illegal_funct)
  );

  always_comb begin
    ctrl        = ctrl_idle();
    state_d     = S_FETCH;
    set_illegal = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.pc_write  = 1'b1;
        state_d        = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        case (OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_SLTI:      state_d = S_SLTIEX;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d     = S_FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        retire          = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        retire         = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = funct_alu_ctrl;
        set_illegal      = illegal_funct;
        state_d          = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = S_IMMWB;
      end
      S_SLTIEX: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = 2'b10;
        ctrl.alu_control = ALU_SLT;
        state_d          = S_IMMWB;
      end
      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_src      = 1'b1;
        ctrl.pc_write    = Zero;  // only Mealy output
        retire           = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    illegal_d = illegal_q | set_illegal;
    count_d   = count_q + CNT_WIDTH'(retire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Write enables are gated by reset so none can fire while it is held.
  assign PCWrite       = ctrl.pc_write  & reset;
  assign MemWrite      = ctrl.mem_write & reset;
  assign IRWrite       = ctrl.ir_write  & reset;
  assign RegWrite      = ctrl.reg_write & reset;
  assign IorD          = ctrl.iord;
  assign RegDst        = ctrl.reg_dst;
  assign MemtoReg      = ctrl.mem_to_reg;
  assign ALUSrcA       = ctrl.alu_src_a;
  assign ALUSrcB       = ctrl.alu_src_b;
  assign ALUControl    = ctrl.alu_control;
  assign PCSrc         = ctrl.pc_src;
  assign illegal_o     = illegal_q;
  assign instr_count_o = count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle control unit.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OP, Funct;
  logic        Zero;
  logic        PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic        ALUSrcA, PCSrc, illegal_o;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl, state_o;
  logic [31:0] instr_count_o;

  int errors = 0;
  int checks = 0;

  multicycle_control_unit #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .illegal_o(illegal_o), .instr_count_o(instr_count_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] exp_state);
    @(posedge clk);
    #1;
    chk("state", 32'(state_o), 32'(exp_state));
  endtask

  logic [5:0] fn_tab [5]  = '{6'h20, 6'h24, 6'h25, 6'h2A, 6'h27};
  logic [3:0] alu_tab [5] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

  initial begin
    reset = 1'b0; OP = 6'h00; Funct = 6'h22; Zero = 1'b0;
    #12;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_pcwrite", 32'(PCWrite), 0);
    chk("rst_irwrite", 32'(IRWrite), 0);
    chk("rst_alusrcb", 32'(ALUSrcB), 1);
    chk("rst_illegal", 32'(illegal_o), 0);
    chk("rst_count", instr_count_o, 0);

    @(negedge clk); reset = 1'b1; #1;
    chk("fetch_pcwrite", 32'(PCWrite), 1);
    chk("fetch_irwrite", 32'(IRWrite), 1);

    // R-type sub
    step(1); chk("dec_alusrcb", 32'(ALUSrcB), 3);
    step(6); chk("ex_aluctl", 32'(ALUControl), 4'b0110);
             chk("ex_alusrca", 32'(ALUSrcA), 1);
             chk("ex_alusrcb", 32'(ALUSrcB), 0);
    step(7); chk("aluwb_regwrite", 32'(RegWrite), 1);
             chk("aluwb_regdst", 32'(RegDst), 1);
    step(0); chk("cnt_sub", instr_count_o, 1);

    // lw
    OP = 6'h23;
    step(1); chk("lw_memwrite", 32'(MemWrite), 0);
    step(2); chk("lw_memwrite", 32'(MemWrite), 0);
    step(3); chk("memrd_iord", 32'(IorD), 1); chk("lw_memwrite", 32'(MemWrite), 0);
    step(4); chk("memwb_memtoreg", 32'(MemtoReg), 1);
             chk("memwb_regwrite", 32'(RegWrite), 1);
             chk("lw_memwrite", 32'(MemWrite), 0);
    step(0); chk("cnt_lw", instr_count_o, 2);

    // sw
    OP = 6'h2B;
    step(1); chk("sw_regwrite", 32'(RegWrite), 0);
    step(2); chk("sw_regwrite", 32'(RegWrite), 0);
    step(5); chk("memwr_memwrite", 32'(MemWrite), 1);
             chk("memwr_iord", 32'(IorD), 1);
             chk("sw_regwrite", 32'(RegWrite), 0);
    step(0); chk("cnt_sw", instr_count_o, 3);

    // beq taken, then Zero toggled inside BRANCH to see the Mealy path
    OP = 6'h04; Zero = 1'b1;
    step(1);
    step(11); chk("br_pcwrite_z1", 32'(PCWrite), 1);
              chk("br_pcsrc", 32'(PCSrc), 1);
              chk("br_aluctl", 32'(ALUControl), 4'b0110);
    Zero = 1'b0; #1;
    chk("br_mealy_z0", 32'(PCWrite), 0);
    Zero = 1'b1;
    step(0); chk("cnt_beq1", instr_count_o, 4);

    // beq not taken
    Zero = 1'b0;
    step(1);
    step(11); chk("br_pcwrite_z0", 32'(PCWrite), 0);
    step(0); chk("cnt_beq0", instr_count_o, 5);

    // illegal opcode
    OP = 6'h3F;
    step(1);
    step(0); chk("illegal_set", 32'(illegal_o), 1);
             chk("cnt_illegal", instr_count_o, 5);

    // addi after illegal
    OP = 6'h08;
    step(1);
    step(8);  chk("addi_alusrcb", 32'(ALUSrcB), 2); chk("addi_aluctl", 32'(ALUControl), 4'b0010);
    step(10); chk("immwb_regwrite", 32'(RegWrite), 1); chk("immwb_regdst", 32'(RegDst), 0);
    step(0);  chk("cnt_addi", instr_count_o, 6); chk("illegal_sticky", 32'(illegal_o), 1);

    // slti
    OP = 6'h0A;
    step(1);
    step(9);  chk("slti_aluctl", 32'(ALUControl), 4'b0111);
    step(10);
    step(0);  chk("cnt_slti", instr_count_o, 7);

    // remaining Funct codes
    OP = 6'h00;
    for (int i = 0; i < 5; i++) begin
      Funct = fn_tab[i];
      step(1);
      step(6); chk("funct_aluctl", 32'(ALUControl), 32'(alu_tab[i]));
      step(7);
      step(0);
    end
    chk("cnt_funct", instr_count_o, 12);

    // reset asserted while in MEMWR
    OP = 6'h2B;
    step(1); step(2); step(5);
    chk("pre_rst_memwrite", 32'(MemWrite), 1);
    #2 reset = 1'b0; #1;
    chk("async_memwrite", 32'(MemWrite), 0);
    chk("async_state", 32'(state_o), 0);
    chk("async_count", instr_count_o, 0);
    chk("async_illegal", 32'(illegal_o), 0);
    chk("async_pcwrite", 32'(PCWrite), 0);

    // illegal Funct: ADD, flagged, still retires
    @(negedge clk); reset = 1'b1; OP = 6'h00; Funct = 6'h3F;
    step(1);
    step(6); chk("badfn_aluctl", 32'(ALUControl), 4'b0010);
    step(7); chk("badfn_illegal", 32'(illegal_o), 1); chk("badfn_regwrite", 32'(RegWrite), 1);
    step(0); chk("badfn_count", instr_count_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style FSM that sequences the multicycle MIPS datapath. It takes OP and Funct from the datapath's instruction register plus the ALU zero flag, and drives every datapath control strobe. Supported instructions: R-type (add, sub, and, or, slt, nor), lw, sw, addi, slti, beq. It also counts retired instructions and flags illegal opcodes.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
OP  input  6  opcode, Instr[31:26] from datapath
Funct  input  6  function field, Instr[5:0] from datapath
Zero  input  1  ALU result == 0, combinational from the datapath ALU
PCWrite  output  1  PC register enable
IorD  output  1  memory address mux select (0 = PC, 1 = ALUOut)
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register enable
RegDst  output  1  A3 mux select (0 = rt, 1 = rd)
MemtoReg  output  1  WD3 mux select (0 = ALUOut, 1 = Data)
RegWrite  output  1  register file write enable
ALUSrcA  output  1  SrcA mux select (0 = PC, 1 = A)
ALUSrcB  output  2  SrcB mux select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2)
ALUControl  output  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
PCSrc  output  1  PC input mux select (0 = ALUResult, 1 = ALUOut)
illegal_o  output  1  sticky illegal-opcode flag
instr_count_o  output  CNT_WIDTH  retired-instruction count
state_o  output  4  current state encoding, for debug

Behaviour:
- Reset (reset == 0, asynchronous): state = FETCH, illegal_o = 0, instr_count_o = 0.
  - While reset is held, PCWrite, MemWrite, IRWrite and RegWrite are forced 0.
  - All other outputs take their FETCH values.
- Unlisted outputs in any state are 0. ALUControl defaults to ADD.
- States and outputs:
  - FETCH(0): IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=0, PCWrite=1. Next: DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut). Next by OP:
    - 0x23 or 0x2B -> MEMADR
    - 0x00 -> EXECUTE
    - 0x08 -> ADDIEX
    - 0x0A -> SLTIEX
    - 0x04 -> BRANCH
    - any other OP -> FETCH; set illegal_o; do not increment the counter.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ADD. Next: MEMRD if OP=0x23, else MEMWR.
  - MEMRD(3): IorD=1. Next: MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR(5): IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUControl from the Funct decode. Next: ALUWB.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - ADDIEX(8): ALUSrcA=1, ALUSrcB=10, ADD. Next: IMMWB.
  - SLTIEX(9): ALUSrcA=1, ALUSrcB=10, SLT. Next: IMMWB.
  - IMMWB(10): RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH(11): ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=1, PCWrite=Zero. Next: FETCH.
- PCWrite in BRANCH is the only Mealy output: combinational from Zero.
- Funct decode:
  - 0x20 -> ADD, 0x22 -> SUB, 0x24 -> AND, 0x25 -> OR, 0x2A -> SLT, 0x27 -> NOR.
  - Any other Funct -> ADD, and set illegal_o in EXECUTE.
  - The instruction still writes back and retires.
- Latency in cycles, FETCH inclusive: lw 5; R-type, sw, addi, slti 4; beq 3; illegal opcode 2.
- instr_count_o increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, IMMWB or BRANCH. It wraps modulo 2^CNT_WIDTH.
- illegal_o stays 1 until reset.
- Reset asserted mid-instruction: the FSM aborts immediately. No write enable is asserted after the asynchronous edge.
- Unused state encodings 12-15 go to FETCH on the next clock.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - the state enum (4-bit codes as listed above);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_BEQ;
  - Funct constants;
  - ALUControl codes.
- One sub-module, alu_decoder: combinational Funct -> ALUControl plus an illegal_funct flag.

Test Plan:
- Release reset, OP=0x00, Funct=0x22 -> states 0,1,6,7,0.
  - EXECUTE: ALUControl=0110, ALUSrcA=1, ALUSrcB=00.
  - ALUWB: RegWrite=1, RegDst=1.
  - instr_count_o becomes 1.
- OP=0x23 -> states 0,1,2,3,4,0.
  - MEMRD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MemWrite stays 0 throughout.
  - Count +1.
- OP=0x2B -> states 0,1,2,5,0. MEMWR: MemWrite=1, IorD=1. RegWrite is never 1.
- OP=0x04 with Zero=1 -> in BRANCH, PCWrite=1, PCSrc=1, ALUControl=0110.
  - Repeat with Zero=0 -> PCWrite=0.
  - Both cases return to FETCH after 3 cycles.
- OP=0x3F -> DECODE returns to FETCH, illegal_o=1, count unchanged.
  - A following addi (OP=0x08) still completes in 4 cycles.
  - illegal_o stays 1 until reset.
- Assert reset in MEMWR -> MemWrite drops to 0 asynchronously, state_o=0, count=0, illegal_o=0.
